wbutxuart: RTL and testbench
============================

# wbutxuart

Serial transmitter at the tail of the debug-bus output chain. It accepts one printable byte per handshake from the six-bit-to-character stage and shifts it onto the UART line as an 8N1 frame: one start bit, eight data bits LSB first, one stop bit. Its busy output is the transmit-busy back-pressure for the entire output pipeline.

## Interface
- CLOCKS_PER_BAUD, 24'd868, clocks per serial bit (115200 baud at 100 MHz); must be ≥ 2.
- i_clk  in  1  system clock.
- i_reset  in  1  reset, synchronous, active-high; clock i_clk.
- i_wr  in  1  byte-valid strobe; upstream holds it and i_data stable while o_busy is high.
- i_data  in  8  character to send.
- o_uart_tx  out  1  serial line, registered, idle high.
- o_busy  out  1  registered; high while a frame is in progress.

## Operation
- Handshake: a byte is accepted on any clock edge where i_wr && !o_busy. i_data is latched into an internal shift register at that edge.
  - i_wr while o_busy is ignored. Nothing is latched and the current frame is unaffected.
- State machine: IDLE → START → BIT0 … BIT7 → STOP → IDLE.
  - Each non-IDLE state lasts exactly CLOCKS_PER_BAUD cycles.
- Baud counter: 24 bits. It loads CLOCKS_PER_BAUD-1 on entry to each non-IDLE state, decrements each cycle, and the state advances when it reaches 0.
  - The counter is held at 0 in IDLE.
- Line value by state:
  - START drives 0.
  - BITn drives data[n]; the shift register shifts right once per bit.
  - STOP and IDLE drive 1.
- o_busy = (state != IDLE), registered to align with o_uart_tx.
- No parity, no break generation, no runtime baud change.
- Reset values: o_uart_tx=1, o_busy=0, state=IDLE, counter=0, shift register=8'hFF.
- Reset mid-frame: the frame is abandoned. The next cycle shows line high and o_busy low, with no partial stop bit. A write arriving in the same cycle as reset is dropped.

## Timing
- Accept at edge T. At T+1, o_busy=1 and o_uart_tx=0 (start bit).
- Data bit n is driven from T+1+(n+1)·CPB through T+(n+2)·CPB.
- The stop bit begins at T+1+9·CPB.
- o_busy falls at T+1+10·CPB. The earliest next accept is that same edge, with its start bit at T+2+10·CPB.
- Minimum frame period is 10·CPB+1 cycles. Back-to-back frames therefore carry one extra idle-high cycle.
- Latency from accept to start-bit edge is 1 cycle. All outputs are glitch-free flop outputs.

## Structure
- Shared package wbu_pkg:
  - state encoding constants: IDLE, START, STOP, and a 4-bit bit index;
  - default CLOCKS_PER_BAUD;
  - 8N1 frame length (10).
- Single module; no sub-module is warranted. The baud counter is inline and small enough that separating it would only add ports.
- Elaboration-time check that CLOCKS_PER_BAUD ≥ 2.

## Test plan
All scenarios use CLOCKS_PER_BAUD=4 unless noted.
- Reset release → o_uart_tx=1, o_busy=0 held for 20 cycles with i_wr=0.
- i_wr with i_data=8'h55, accepted at T:
  - line is 0 from T+1..T+4;
  - data bits are 1,0,1,0,1,0,1,0, each 4 cycles, from T+5;
  - stop bit is high from T+37..T+40;
  - o_busy falls at T+41.
- i_wr held continuously with 8'h41 then 8'h0A:
  - second byte accepted at T+41, start bit at T+42;
  - decoded stream is exactly 0x41, 0x0A.
- Mid-frame i_data change with i_wr=1 (8'hA5 → 8'h3C while busy): frame still carries 8'hA5, and the 8'h3C is accepted only after o_busy falls.
- i_reset asserted during BIT3 → next cycle o_uart_tx=1, o_busy=0. A following 8'hFF write produces a clean 41-cycle frame.
- CLOCKS_PER_BAUD=868, byte 8'h00 → line low for 9·868 cycles, o_busy high for exactly 8680 cycles.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared constants for the debug-bus output chain: UART transmitter state encoding,
// default baud divisor and frame length.
package wbu_pkg;

  localparam logic [23:0] DefaultClocksPerBaud = 24'd868;
  localparam int unsigned FrameBits = 10;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StStart = 4'd1,
    StBit0  = 4'd2,
    StBit1  = 4'd3,
    StBit2  = 4'd4,
    StBit3  = 4'd5,
    StBit4  = 4'd6,
    StBit5  = 4'd7,
    StBit6  = 4'd8,
    StBit7  = 4'd9,
    StStop  = 4'd10
  } wbu_state_e;

  // Data bit carried by a BITn state; meaningless for other states.
  function automatic logic [3:0] bit_index(input wbu_state_e st);
    return 4'(st) - 4'(StBit0);
  endfunction

endpackage

// File: rtl/wbutxuart.sv
// 8N1 UART transmitter; o_busy is the back-pressure for the whole output pipeline.
// Outputs are flops loaded from the next state, so they switch on the same edge as the FSM.
module wbutxuart
  import wbu_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = DefaultClocksPerBaud
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_uart_tx,
  output logic       o_busy
);

  if (CLOCKS_PER_BAUD < 24'd2) begin : g_bad_cpb
    $error("wbutxuart: CLOCKS_PER_BAUD must be at least 2");
  end

  wbu_state_e  state_q, state_d;
  logic [23:0] baud_q, baud_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        accept;

  assign accept = i_wr && !busy_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    shift_d = shift_q;

    if (state_q == StIdle) begin
      baud_d = '0;
      if (accept) begin
        state_d = StStart;
        baud_d  = CLOCKS_PER_BAUD - 24'd1;
        shift_d = i_data;
      end
    end else if (baud_q != '0) begin
      baud_d = baud_q - 24'd1;
    end else if (state_q == StStop) begin
      state_d = StIdle;
      baud_d  = '0;
    end else begin
      state_d = wbu_state_e'(4'(state_q) + 4'd1);
      baud_d  = CLOCKS_PER_BAUD - 24'd1;
      // BIT0 uses the freshly latched LSB; every later bit needs one shift.
      if (state_q != StStart) begin
        shift_d = {1'b1, shift_q[7:1]};
      end
    end

    busy_d = (state_d != StIdle);

    unique case (state_d)
      StStart: tx_d = 1'b0;
      StBit0, StBit1, StBit2, StBit3,
      StBit4, StBit5, StBit6, StBit7: tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      shift_q <= 8'hFF;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_wbutxuart.sv
// Randomized bench for wbutxuart: a frame-level model predicts the line and busy
// for every cycle from the accept time and byte alone.
module tb_wbutxuart;

  localparam int unsigned Cpb     = 4;
  localparam int unsigned CpbSlow = 868;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       wr_slow = 1'b0;
  logic [7:0] data_slow = 8'h00;
  logic       tx, busy, tx_slow, busy_slow;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;

  // Frame model: one active frame, its first output cycle and its byte.
  bit          m_active = 1'b0;
  int unsigned m_start = 0;
  logic [7:0]  m_byte = 8'h00;
  bit          m_acc = 1'b0;

  always #5 i_clk = ~i_clk;

  wbutxuart #(.CLOCKS_PER_BAUD(24'(Cpb))) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr     (i_wr),
    .i_data   (i_data),
    .o_uart_tx(tx),
    .o_busy   (busy)
  );

  wbutxuart #(.CLOCKS_PER_BAUD(24'(CpbSlow))) dut_slow (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr     (wr_slow),
    .i_data   (data_slow),
    .o_uart_tx(tx_slow),
    .o_busy   (busy_slow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  // {busy, line} for the current cycle: start slot, 8 data slots LSB first, stop slot.
  function automatic logic [1:0] model_out();
    int unsigned t, slot;
    if (!m_active || cyc < m_start) return 2'b01;
    t = cyc - m_start;
    if (t >= 10 * Cpb) return 2'b01;
    slot = t / Cpb;
    if (slot == 0) return 2'b10;
    if (slot == 9) return 2'b11;
    return {1'b1, m_byte[slot-1]};
  endfunction

  // Called at a falling edge: check this cycle, apply inputs for the next rising edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rst);
    logic [1:0] e;
    e = model_out();
    check_eq("busy", 32'(busy), 32'(e[1]));
    check_eq("line", 32'(tx), 32'(e[0]));
    i_wr    = wr;
    i_data  = d;
    i_reset = rst;
    m_acc   = 1'b0;
    if (rst) begin
      m_active = 1'b0;
    end else if (wr && !e[1]) begin
      m_active = 1'b1;
      m_start  = cyc + 1;
      m_byte   = d;
      m_acc    = 1'b1;
    end
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic send_until_acc(input logic [7:0] d);
    int unsigned n = 0;
    do begin
      step(1'b1, d, 1'b0);
      n++;
    end while (!m_acc && n < 200);
    if (!m_acc) check_eq("accept_bound", n, 0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int unsigned n, low;
    @(posedge i_clk);
    @(negedge i_clk);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check_eq("slow_reset_busy", 32'(busy_slow), 0);
    check_eq("slow_reset_line", 32'(tx_slow), 1);
    idle(20);

    // Single 0x55 frame from idle.
    step(1'b1, 8'h55, 1'b0);
    idle(45);

    // Back-to-back with i_wr held: 0x41 then 0x0A.
    send_until_acc(8'h41);
    send_until_acc(8'h0A);
    idle(45);

    // Data changes while busy must not leak into the current frame.
    send_until_acc(8'hA5);
    send_until_acc(8'h3C);
    idle(45);

    // Reset in BIT3 with a simultaneous write, then a clean 0xFF frame.
    send_until_acc(8'h99);
    idle(4 * Cpb + 1);
    step(1'b1, 8'h77, 1'b1);
    idle(3);
    send_until_acc(8'hFF);
    idle(45);

    // Random bytes, gaps and ignored writes while busy.
    for (int i = 0; i < 10; i++) begin
      idle($urandom_range(0, 3));
      send_until_acc(8'($urandom));
      repeat ($urandom_range(0, 50)) step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end
    idle(45);

    // Full-rate divisor: byte 0x00.
    check_eq("slow_idle_busy", 32'(busy_slow), 0);
    wr_slow   = 1'b1;
    data_slow = 8'h00;
    @(posedge i_clk);
    @(negedge i_clk);
    wr_slow = 1'b0;
    n = 0;
    low = 0;
    while (busy_slow && n < 10000) begin
      if (!tx_slow) low++;
      n++;
      @(posedge i_clk);
      @(negedge i_clk);
    end
    check_eq("slow_busy_cycles", n, 10 * CpbSlow);
    check_eq("slow_low_cycles", low, 9 * CpbSlow);
    check_eq("slow_end_line", 32'(tx_slow), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
